// File: rtl/toggle_handshake_rx.sv
// Receive end of a 2-phase toggle handshake: synchronises req_tgl, presents each
// request as one valid/ready word and toggles ack_tgl once that word is accepted.
module toggle_handshake_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_tgl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              proto_err,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_seen_q, req_seen_d;
  logic                   ack_q, ack_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   req_sync;
  logic                   pending;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], req_tgl};
  assign req_sync = sync_q[SYNC_STAGES-1];
  assign pending  = (req_sync != req_seen_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending)   state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = (state_q == HOLD);
    out_data   = data_q;
    ack_tgl    = ack_q;
    proto_err  = err_q;
    xfer_count = count_q;
  end

  // A request arriving during HOLD stays pending (req_seen untouched) and is taken in IDLE.
  always_comb begin
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    data_d     = data_q;
    err_d      = err_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (pending) begin
          data_d     = data_in;
          req_seen_d = req_sync;
        end
      end
      HOLD: begin
        if (out_ready) begin
          ack_d   = ~ack_q;
          count_d = count_q + CNT_W'(1);
        end
        if (pending) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q     <= '0;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Scoreboard bench for toggle_handshake_rx: a toggle sender queues expected words,
// a negedge monitor checks accepted words, ack parity, counter and hold rules.
module tb_toggle_handshake_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_tgl = 1'b0;
  logic [7:0] data_in = '0;
  logic       ack_tgl;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       proto_err;
  logic [3:0] xfer_count;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         accept_cnt = 0;
  logic       req_level = 1'b0;
  logic       ready_cmd = 1'b0;
  logic       rand_ready = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_accept = 1'b0;
  logic [7:0] prev_data = '0;

  toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req_tgl(req_tgl), .data_in(data_in),
    .ack_tgl(ack_tgl), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .proto_err(proto_err), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got timeout expected completion", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent model: every accepted word is popped in order; ack parity and count follow accepts.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      accept_cnt  = 0;
      prev_valid  = 1'b0;
      prev_accept = 1'b0;
    end else begin
      check_output("ack_parity", 32'(ack_tgl), 32'(accept_cnt % 2));
      check_output("xfer_count", 32'(xfer_count), 32'(accept_cnt % 16));
      if (prev_accept) check_output("idle_gap", 32'(out_valid), 32'd0);
      if (prev_valid && !prev_accept) begin
        check_output("hold_valid", 32'(out_valid), 32'd1);
        check_output("hold_data", 32'(out_data), 32'(prev_data));
      end
      prev_accept = out_valid && out_ready;
      prev_valid  = out_valid;
      prev_data   = out_data;
      if (prev_accept) begin
        if (exp_q.size() == 0) fail_now("unexpected_word");
        else check_output("word_data", 32'(out_data), 32'(exp_q.pop_front()));
        accept_cnt++;
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    req_tgl = ~req_tgl;
    tick();
    req_tgl = ~req_tgl;
    tick();
    req_tgl   = 1'b0;
    req_level = 1'b0;
    data_in   = '0;
    tick();
    reset = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [7:0] d);
    int n = 0;
    while (ack_tgl != req_level && n < 300) begin
      tick();
      n++;
    end
    if (ack_tgl != req_level) fail_now("sender_wait_ack");
    data_in   = d;
    req_tgl   = ~req_tgl;
    req_level = req_tgl;
    exp_q.push_back(d);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) fail_now("wait_valid");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ack_tgl == req_level && !out_valid) && n < 600) begin
      tick();
      n++;
    end
    if (!(ack_tgl == req_level && !out_valid)) fail_now("wait_idle");
  endtask

  initial begin
    ready_cmd = 1'b1;
    apply_reset();
    tick();
    check_output("rst_ack", 32'(ack_tgl), 32'd0);
    check_output("rst_valid", 32'(out_valid), 32'd0);
    check_output("rst_err", 32'(proto_err), 32'd0);
    check_output("rst_count", 32'(xfer_count), 32'd0);

    // Single word latency with SYNC_STAGES=2
    apply_stimulus(8'hA5);
    tick();
    check_output("lat_n", 32'(out_valid), 32'd0);
    tick();
    check_output("lat_n1", 32'(out_valid), 32'd0);
    tick();
    check_output("lat_n2_valid", 32'(out_valid), 32'd1);
    check_output("lat_n2_data", 32'(out_data), 32'hA5);
    tick();
    check_output("lat_n3_ack", 32'(ack_tgl), 32'd1);
    check_output("lat_n3_count", 32'(xfer_count), 32'd1);

    // Backpressure
    ready_cmd = 1'b0;
    apply_stimulus(8'h3C);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("bp_valid", 32'(out_valid), 32'd1);
      check_output("bp_data", 32'(out_data), 32'h3C);
      check_output("bp_ack", 32'(ack_tgl), 32'd1);
    end
    ready_cmd = 1'b1;
    tick();
    tick();
    check_output("bp_ack_flip", 32'(ack_tgl), 32'd0);
    check_output("bp_valid_drop", 32'(out_valid), 32'd0);

    // Back-to-back words
    for (int i = 1; i <= 4; i++) apply_stimulus(8'(i));
    wait_idle();
    check_output("b2b_count", 32'(xfer_count), 32'd6);
    check_output("b2b_ack", 32'(ack_tgl), 32'd0);

    // Random traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      apply_stimulus(8'($urandom));
    end
    wait_idle();
    rand_ready = 1'b0;
    check_output("rand_count", 32'(xfer_count), 32'd10);
    check_output("rand_err", 32'(proto_err), 32'd0);

    // Protocol violation: second request while the first is held
    ready_cmd = 1'b0;
    apply_stimulus(8'h11);
    wait_valid();
    data_in   = 8'h22;
    req_tgl   = ~req_tgl;
    req_level = req_tgl;
    exp_q.push_back(8'h22);
    for (int i = 0; i < 4; i++) tick();
    check_output("viol_err", 32'(proto_err), 32'd1);
    check_output("viol_hold", 32'(out_data), 32'h11);
    ready_cmd = 1'b1;
    wait_idle();
    check_output("viol_err_sticky", 32'(proto_err), 32'd1);
    check_output("viol_count", 32'(xfer_count), 32'd12);

    // Counter wrap after 16 transfers
    apply_reset();
    tick();
    check_output("rst2_err", 32'(proto_err), 32'd0);
    rand_ready = 1'b1;
    for (int i = 0; i < 15; i++) apply_stimulus(8'($urandom));
    wait_idle();
    check_output("wrap_15", 32'(xfer_count), 32'd15);
    apply_stimulus(8'h5A);
    wait_idle();
    check_output("wrap_0", 32'(xfer_count), 32'd0);
    apply_stimulus(8'h77);
    wait_idle();
    rand_ready = 1'b0;
    check_output("pre_rst_ack", 32'(ack_tgl), 32'd1);

    // Reset in the middle of HOLD
    ready_cmd = 1'b0;
    apply_stimulus(8'hC3);
    wait_valid();
    reset = 1'b0;
    tick();
    check_output("midrst_valid", 32'(out_valid), 32'd0);
    check_output("midrst_ack", 32'(ack_tgl), 32'd0);
    check_output("midrst_count", 32'(xfer_count), 32'd0);
    req_tgl   = 1'b0;
    req_level = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    check_output("post_rst_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
